jtgng_objdma: RTL
=================

# jtgng_objdma

Object-RAM DMA engine for the main CPU board. It sits directly downstream of the main CPU block's shared 8 kB work RAM. At the start of each vertical blank it halts the 6809 through `bus_req`/`bus_ack` and takes over the RAM with `blcnten`/`obj_AB`. It then copies the sprite table (0x1E00 onward) into a private line-buffer RAM, which the object renderer reads at any time during active video.

## Interface
Parameters:
- `OBJMAX`, default 384: number of bytes copied per frame (96 objects × 4 bytes). Legal range 2–512.

Ports:
- `clk` in 1: system clock. Reset is synchronous and active-low on `rst_n`.
- `rst_n` in 1: synchronous active-low reset.
- `cen6` in 1: 6 MHz clock enable; all state except the read port advances only on `cen6`.
- `LVBL` in 1: vertical blank when 0.
- `bus_ack` in 1: CPU has released the bus (BA && BS).
- `bus_req` out 1: halt request to the CPU (drives nHALT low).
- `blcnten` out 1: RAM address mux select; 1 routes `obj_AB` to the RAM and blocks CPU writes.
- `obj_AB` out 9: RAM address offset; the RAM sees {4'hf, obj_AB}.
- `ram_dout` in 8: RAM read data, valid one `cen6` after the address.
- `rd_addr` in 9: renderer read address.
- `rd_data` out 8: renderer read data.
- `dma_busy` out 1: high from REQ through FLUSH.
- `dma_done` out 1: one-`clk` pulse when a copy completes.

## Operation
- `last_LVBL` is registered on `cen6`. A falling-edge trigger is `last_LVBL && !LVBL`.
- States:
  - IDLE: on trigger → REQ.
  - REQ: `bus_req`=1. On `cen6` with `bus_ack`=1 → COPY, with `obj_AB`=0 and `blcnten`=1.
  - COPY: on each `cen6` with `bus_ack`=1:
    - `obj_AB` increments.
    - The previous address, held in `wr_addr`, is written into the buffer with `ram_dout`, starting from the second COPY `cen6`.
    - When `obj_AB`==OBJMAX-1 → FLUSH.
  - FLUSH: on one `cen6`, write the last byte (`wr_addr`=OBJMAX-1) → DONE.
  - DONE: `bus_req`=0, `blcnten`=0, `dma_done`=1 for one `clk` → IDLE.
- `bus_ack` falling during COPY/FLUSH: counter and writes freeze, and `blcnten` stays 1; resume when `bus_ack` returns. Neither the `bus_req` nor the `blcnten` output changes.
- LVBL rising mid-copy: ignored; the copy runs to completion.
- Trigger while not IDLE: ignored; no queueing.
- Buffer addresses ≥ OBJMAX are never written and keep their prior contents (undefined after power-up).
- `rd_data` = buffer[`rd_addr`], registered, one `clk` latency, not gated by `cen6`. A read concurrent with a write to the same address returns old data.

## Timing
- Reset values: `bus_req`=0, `blcnten`=0, `obj_AB`=0, `dma_busy`=0, `dma_done`=0, `last_LVBL`=1, state IDLE. The buffer contents are not reset.
- Trigger to `bus_req`: `bus_req` rises on the same `cen6` that detects the falling edge.
- `blcnten` and `obj_AB`=0 change together on the `cen6` that samples `bus_ack`=1.
- Copy duration with uninterrupted `bus_ack`: OBJMAX `cen6` in COPY + 1 in FLUSH + 1 in DONE. For OBJMAX=384, `bus_req` is high for 386 `cen6` periods plus the ack wait.
- Buffer write for address k occurs on the `cen6` after `obj_AB`=k was presented.
- `rst_n` low mid-copy: `bus_req` and `blcnten` drop on the next `clk` edge regardless of `cen6`. No `dma_done` is issued.

## Configuration
- `JTGNG_OBJDMA_DBLBUF_EN` defined: the buffer is 2×512 bytes.
  - The DMA writes bank `wbank`; `rd_data` reads bank `~wbank`.
  - `wbank` toggles in DONE, so the renderer only ever sees a complete frame.
  - `wbank` resets to 0.
  - A copy aborted by reset does not toggle `wbank`.
- Undefined: single 512-byte bank. The renderer reads the same bank being written, and tearing during a copy is accepted.

## Test plan
- Fill CPU RAM 0x1E00+i with i^8'h5A; pulse LVBL low; hold `bus_ack` high 3 `cen6` after `bus_req` → after `dma_done`, `rd_addr`=i returns i^8'h5A for i=0..383; `bus_req` high exactly 386 `cen6` after ack.
- Drop `bus_ack` for 10 `cen6` when `obj_AB`=100 → `obj_AB` holds at 100, no buffer writes, `blcnten` stays 1; final contents identical to the first test.
- Assert `rst_n`=0 when `obj_AB`=200 → next `clk`: `bus_req`=0, `blcnten`=0, `dma_busy`=0, no `dma_done`; the next LVBL fall performs a full copy.
- Second LVBL falling edge while in COPY → ignored; exactly one `dma_done` per frame.
- Double-buffer build: during the second frame's copy, `rd_data` returns frame-1 values at all addresses; after DONE it returns frame-2 values. Single-buffer build: the address already written (e.g. 50 when `obj_AB`=120) shows frame-2 data mid-copy.
- Buffer address 400 preloaded with 8'hA5 by a prior OBJMAX=512 run, then OBJMAX=384 → `rd_addr`=400 still returns 8'hA5.

Source files
------------

// File: rtl/jtgng_objdma_if.sv
// Bus-handover and work-RAM read path between the object DMA (master) and the
// main CPU board (slave): halt handshake, address-mux select, address and read data.
interface jtgng_objdma_if;
    logic       bus_req;
    logic       bus_ack;
    logic       blcnten;
    logic [8:0] obj_AB;
    logic [7:0] ram_dout;

    modport master (
        output bus_req,
        output blcnten,
        output obj_AB,
        input  bus_ack,
        input  ram_dout
    );

    modport slave (
        input  bus_req,
        input  blcnten,
        input  obj_AB,
        output bus_ack,
        output ram_dout
    );
endinterface

// File: rtl/jtgng_objdma.sv
// Object-RAM DMA: on each vertical-blank start, halts the CPU and copies OBJMAX sprite bytes
// from work RAM 0x1E00+ into a private buffer. Define JTGNG_OBJDMA_DBLBUF_EN for a 2x512 buffer.
module jtgng_objdma #(
    parameter int unsigned OBJMAX = 384
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cen6,
    input  logic                  LVBL,
    jtgng_objdma_if.master        bus,
    input  logic [8:0]            rd_addr,
    output logic [7:0]            rd_data,
    output logic                  dma_busy,
    output logic                  dma_done
);

`ifdef JTGNG_OBJDMA_DBLBUF_EN
    localparam int unsigned BUF_SIZE = 1024;
`else
    localparam int unsigned BUF_SIZE = 512;
`endif
    localparam int unsigned AW   = $clog2(BUF_SIZE);
    localparam logic [8:0]  LAST = 9'(OBJMAX - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        COPY,
        FLUSH,
        DONE
    } state_t;

    state_t        state;
    logic          last_LVBL;
    logic          trigger;
    logic [8:0]    wr_addr;
    logic          wr_en;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    logic [7:0]    buffer [BUF_SIZE];
`ifdef JTGNG_OBJDMA_DBLBUF_EN
    logic          wbank;
`endif

    always_comb begin
        trigger = last_LVBL && !LVBL;
        // RAM data lags the address by one cen6, so the first COPY step (obj_AB still 0) only primes the pipeline
        wr_en   = rst_n && cen6 && bus.bus_ack &&
                  ((state == COPY && bus.obj_AB != '0) || state == FLUSH);
`ifdef JTGNG_OBJDMA_DBLBUF_EN
        wr_idx  = {wbank, wr_addr};
        rd_idx  = {~wbank, rd_addr};
`else
        wr_idx  = wr_addr;
        rd_idx  = rd_addr;
`endif
    end

    always_ff @(posedge clk) begin
        dma_done <= 1'b0;
        if (!rst_n) begin
            state       <= IDLE;
            last_LVBL   <= 1'b1;
            bus.bus_req <= 1'b0;
            bus.blcnten <= 1'b0;
            bus.obj_AB  <= '0;
            wr_addr     <= '0;
            dma_busy    <= 1'b0;
            dma_done    <= 1'b0;
`ifdef JTGNG_OBJDMA_DBLBUF_EN
            wbank       <= 1'b0;
`endif
        end else if (cen6) begin
            last_LVBL <= LVBL;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        state       <= REQ;
                        bus.bus_req <= 1'b1;
                        dma_busy    <= 1'b1;
                    end
                end
                REQ: begin
                    if (bus.bus_ack) begin
                        state       <= COPY;
                        bus.blcnten <= 1'b1;
                        bus.obj_AB  <= '0;
                    end
                end
                COPY: begin
                    if (bus.bus_ack) begin
                        wr_addr <= bus.obj_AB;
                        if (bus.obj_AB == LAST) begin
                            state <= FLUSH;
                        end else begin
                            bus.obj_AB <= bus.obj_AB + 9'd1;
                        end
                    end
                end
                FLUSH: begin
                    if (bus.bus_ack) begin
                        state    <= DONE;
                        dma_busy <= 1'b0;
                    end
                end
                DONE: begin
                    state       <= IDLE;
                    bus.bus_req <= 1'b0;
                    bus.blcnten <= 1'b0;
                    dma_done    <= 1'b1;
`ifdef JTGNG_OBJDMA_DBLBUF_EN
                    wbank       <= ~wbank;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read-before-write: a same-address read in the write cycle returns the old byte
    always_ff @(posedge clk) begin
        if (wr_en) begin
            buffer[wr_idx] <= bus.ram_dout;
        end
        rd_data <= buffer[rd_idx];
    end

endmodule
